sync_sequence_transmitter: RTL and testbench

//  Serial frame transmitter for the 1011 sequence detector. Accepts a parallel word on a valid/ready

---
 rtl/sync_sequence_transmitter_pkg.sv | 12 +
 rtl/sync_sequence_transmitter_piso_shift_reg.sv | 19 +
 rtl/sync_sequence_transmitter.sv | 109 ++++++++++
 tb/tb_sync_sequence_transmitter.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sync_sequence_transmitter_pkg.sv
// sync_sequence_transmitter_pkg: shared sync constants, FSM state encoding and sizing helper.
package sync_sequence_transmitter_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, PAY = 2'd2, GAP = 2'd3} state_e;
    localparam int SYNC_W = 4;
    localparam logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011;
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction
endpackage

// File: rtl/sync_sequence_transmitter_piso_shift_reg.sv
// piso_shift_reg: parallel-load, shift-left register exposing its MSB.
module piso_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         msb_o
);
    logic [W-1:0] sh_q;
    always_ff @(posedge clk) begin
        if (!rst) sh_q <= '0;
        else if (load_i) sh_q <= data_i;
        else if (shift_i) sh_q <= sh_q << 1;
    end
    assign msb_o = sh_q[W-1];
endmodule

// File: rtl/sync_sequence_transmitter.sv
// sync_sequence_transmitter: serialises a word as sync preamble, MSB-first payload, then guard bits.
module sync_sequence_transmitter
    import sync_sequence_transmitter_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                PRE_W    = SYNC_W,
    parameter logic [PRE_W-1:0]  PREAMBLE = SYNC_PATTERN,
    parameter int                GAP_LEN  = 1,
    parameter logic              IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              frame_start,
    output logic              frame_done,
    output logic [1:0]        state
);
    localparam int CW     = $clog2(max4(PRE_W, DATA_W, GAP_LEN, 2));
    localparam int PIW    = PRE_W > 1 ? $clog2(PRE_W) : 1;
    localparam int GAP_M1 = GAP_LEN > 0 ? GAP_LEN - 1 : 0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_m1;
    logic          out_q, out_d, start_q, start_d, done_q, done_d;
    logic          load, shift, msb;

    piso_shift_reg #(.W(DATA_W)) u_sh (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .shift_i(shift),
        .data_i (data_in),
        .msb_o  (msb)
    );

    assign cnt_m1      = cnt_q - 1'b1;
    // Nothing is accepted while reset is held, even though the state already reads IDLE.
    assign ready       = rst && state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign out         = out_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = IDLE_BIT;
        start_d = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: if (valid && ready) begin
                load    = 1'b1;
                out_d   = PREAMBLE[PRE_W-1];
                cnt_d   = CW'(PRE_W - 1);
                state_d = PRE;
                start_d = 1'b1;
            end
            // The word is shifted as each bit leaves, so the register MSB is always the next bit to send.
            PRE: if (cnt_q == '0) begin
                out_d   = msb;
                shift   = 1'b1;
                cnt_d   = CW'(DATA_W - 1);
                state_d = PAY;
            end else begin
                out_d = PREAMBLE[cnt_m1[PIW-1:0]];
                cnt_d = cnt_m1;
            end
            PAY: if (cnt_q == '0) begin
                cnt_d   = GAP_LEN > 0 ? CW'(GAP_M1) : cnt_q;
                state_d = GAP_LEN > 0 ? GAP : IDLE;
                done_d  = GAP_LEN == 0;
            end else begin
                out_d = msb;
                shift = 1'b1;
                cnt_d = cnt_m1;
            end
            GAP: if (cnt_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_m1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= IDLE_BIT;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_sync_sequence_transmitter.sv
// tb_sync_sequence_transmitter: directed checks of framing, handshake, reset and detector loopback.
module tb_sync_sequence_transmitter;
    logic       clk = 1'b0, rst = 1'b0, valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       ready, out, busy, frame_start, frame_done;
    logic [1:0] state;
    logic [2:0] hist_q = 3'b000;
    logic       det;
    int         n_assert = 0, n_fail = 0;

    sync_sequence_transmitter dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid      (valid),
        .ready      (ready),
        .out        (out),
        .busy       (busy),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Reference Mealy 1011 detector (overlapping) watching the serial line.
    always @(posedge clk) hist_q <= {hist_q[1:0], out};
    assign det = {hist_q, out} == 4'b1011;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        data_in = d;
        valid   = 1'b1;
        step();
    endtask

    // Called in cycle 1 of a frame. mode 0: valid low; 1: random valid/data while busy; 2: leave valid alone.
    task automatic check_frame(input logic [7:0] w, input int mode, input bit det_chk);
        logic [11:0] bits;
        bits = {4'b1011, w};
        for (int i = 0; i < 14; i++) begin
            if (i > 0) step();
            if (i == 0 && mode != 2) valid = 1'b0;
            chk($sformatf("out[%0d]", i), out, i < 12 ? bits[11-i] : 1'b0);
            chk($sformatf("state[%0d]", i), state, i < 4 ? 1 : i < 12 ? 2 : i == 12 ? 3 : 0);
            chk($sformatf("busy[%0d]", i), busy, i < 13);
            chk($sformatf("ready[%0d]", i), ready, i == 13);
            chk($sformatf("frame_start[%0d]", i), frame_start, i == 0);
            chk($sformatf("frame_done[%0d]", i), frame_done, i == 13);
            if (det_chk) chk($sformatf("det[%0d]", i), det, i == 3);
            if (mode == 1) begin
                valid   = i < 12 ? 1'($urandom_range(0, 1)) : 1'b0;
                data_in = 8'($urandom);
            end
        end
    endtask

    initial begin
        // reset held with valid high
        valid   = 1'b1;
        data_in = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ready", ready, 0);
            chk("rst_out", out, 0);
            chk("rst_busy", busy, 0);
            chk("rst_fs", frame_start, 0);
            chk("rst_fd", frame_done, 0);
        end
        valid = 1'b0;
        rst   = 1'b1;
        step();
        chk("post_rst_ready", ready, 1);
        chk("post_rst_state", state, 0);
        chk("post_rst_out", out, 0);

        // single frame of A5
        send(8'hA5);
        check_frame(8'hA5, 0, 0);

        // back-to-back with valid held: FF then 00, 14 cycles apart
        data_in = 8'hFF;
        valid   = 1'b1;
        step();
        data_in = 8'h00;
        check_frame(8'hFF, 2, 0);
        step();
        valid = 1'b0;
        check_frame(8'h00, 0, 0);

        // noise on valid/data_in while busy
        step();
        send(8'h96);
        check_frame(8'h96, 1, 0);

        // reset mid-payload of C3 at payload bit 3
        step();
        send(8'hC3);
        valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("c3_bit3_out", out, 0);
        chk("c3_bit3_state", state, 2);
        rst = 1'b0;
        step();
        chk("midrst_out", out, 0);
        chk("midrst_state", state, 0);
        chk("midrst_fd", frame_done, 0);
        chk("midrst_busy", busy, 0);
        rst = 1'b1;
        step();
        chk("after_midrst_fd", frame_done, 0);
        chk("after_midrst_ready", ready, 1);
        send(8'h3C);
        check_frame(8'h3C, 0, 0);

        // detector loopback with zero payload
        step();
        step();
        send(8'h00);
        check_frame(8'h00, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
